// File: rtl/frame_grab_ctrl.sv
// Single-shot frame capture into the pixel buffer, then byte-wise drain
// to the UART with an idle holdoff before each write.
module frame_grab_ctrl #(
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 307200,
  parameter int HOLDOFF      = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              pix_valid,
  input  logic [7:0]        pix_data,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_waddr,
  output logic [7:0]        buf_wdata,
  output logic [ADDR_W-1:0] buf_raddr,
  input  logic [7:0]        buf_rdata,
  output logic              tx_wr,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   pix_count
);

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD = HW'(HOLDOFF);
  localparam logic [HW-1:0] H_ONE = HW'(1);
  localparam logic [ADDR_W:0] FP = (ADDR_W + 1)'(FRAME_PIXELS);
  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FS,
    S_CAPTURE,
    S_DRAIN_RD,
    S_DRAIN_LAT,
    S_DRAIN_LATCH,
    S_DRAIN_WAIT,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_nxt;
  logic              r_buf_we;
  logic [ADDR_W-1:0] r_buf_waddr;
  logic [7:0]        r_buf_wdata;
  logic [ADDR_W:0]   r_raddr;
  logic [7:0]        r_tx_data;
  logic              r_overflow;
  logic [ADDR_W:0]   r_pix_count;
  logic [HW-1:0]     r_hcnt;

  logic              w_store;
  logic              w_ovf;
  logic              w_tx_wr;
  logic              w_clear;
  logic              w_drain0;
  logic [ADDR_W:0]   w_cnt_nxt;
  logic [ADDR_W:0]   w_raddr_inc;

  assign w_raddr_inc = r_raddr + ONE;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_store   = 1'b0;
    w_ovf     = 1'b0;
    w_tx_wr   = 1'b0;
    w_clear   = 1'b0;
    w_drain0  = 1'b0;
    w_cnt_nxt = r_pix_count;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          w_nxt   = S_WAIT_FS;
          w_clear = 1'b1;
        end
      end
      S_WAIT_FS: begin
        if (frame_start) w_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (pix_valid) begin
          if (r_pix_count < FP) begin
            w_store   = 1'b1;
            w_cnt_nxt = r_pix_count + ONE;
          end else begin
            w_ovf = 1'b1;
          end
        end
        if (frame_end) begin
          w_drain0 = 1'b1;
          w_nxt    = (w_cnt_nxt == '0) ? S_DONE : S_DRAIN_RD;
        end
      end
      S_DRAIN_RD:    w_nxt = S_DRAIN_LAT;
      S_DRAIN_LAT:   w_nxt = S_DRAIN_LATCH;
      S_DRAIN_LATCH: w_nxt = S_DRAIN_WAIT;
      S_DRAIN_WAIT: begin
        if (r_hcnt == HOLD && !tx_busy) begin
          w_tx_wr = 1'b1;
          w_nxt   = (w_raddr_inc == r_pix_count) ? S_DONE : S_DRAIN_RD;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_we    <= 1'b0;
      r_buf_waddr <= '0;
      r_buf_wdata <= '0;
      r_raddr     <= '0;
      r_tx_data   <= '0;
      r_overflow  <= 1'b0;
      r_pix_count <= '0;
      r_hcnt      <= '0;
    end else begin
      r_buf_we <= w_store;
      if (w_store) begin
        r_buf_waddr <= r_pix_count[ADDR_W-1:0];
        r_buf_wdata <= pix_data;
      end
      if (w_clear) begin
        r_pix_count <= '0;
        r_overflow  <= 1'b0;
        r_buf_waddr <= '0;
      end else begin
        r_pix_count <= w_cnt_nxt;
        if (w_ovf) r_overflow <= 1'b1;
      end
      if (w_drain0)     r_raddr <= '0;
      else if (w_tx_wr) r_raddr <= w_raddr_inc;
      if (r_state == S_DRAIN_LATCH) r_tx_data <= buf_rdata;
      // holdoff only accumulates uninterrupted idle cycles in DRAIN_WAIT
      if (r_state != S_DRAIN_WAIT || tx_busy || w_tx_wr) r_hcnt <= '0;
      else if (r_hcnt != HOLD) r_hcnt <= r_hcnt + H_ONE;
    end
  end

  assign buf_we    = r_buf_we;
  assign buf_waddr = r_buf_waddr;
  assign buf_wdata = r_buf_wdata;
  assign buf_raddr = r_raddr[ADDR_W-1:0];
  assign tx_wr     = w_tx_wr;
  assign tx_data   = r_tx_data;
  assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done      = (r_state == S_DONE);
  assign overflow  = r_overflow;
  assign pix_count = r_pix_count;

endmodule

// File: tb/tb_frame_grab_ctrl.sv
// Scoreboard bench for frame_grab_ctrl with a buffer model and a
// UART model that stays busy 10 cycles after each write.
module tb_frame_grab_ctrl;

  localparam int AW = 5;
  localparam int FP = 16;
  localparam int HO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          frame_start;
  logic          frame_end;
  logic          pix_valid;
  logic [7:0]    pix_data;
  logic          buf_we;
  logic [AW-1:0] buf_waddr;
  logic [7:0]    buf_wdata;
  logic [AW-1:0] buf_raddr;
  logic [7:0]    buf_rdata;
  logic          tx_wr;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW:0]   pix_count;

  frame_grab_ctrl #(
    .ADDR_W(AW),
    .FRAME_PIXELS(FP),
    .HOLDOFF(HO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arm(arm),
    .frame_start(frame_start),
    .frame_end(frame_end),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .buf_we(buf_we),
    .buf_waddr(buf_waddr),
    .buf_wdata(buf_wdata),
    .buf_raddr(buf_raddr),
    .buf_rdata(buf_rdata),
    .tx_wr(tx_wr),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         wr_seen = 0;
  int         tx_seen = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [32];
  logic [7:0] rdata_q;
  assign buf_rdata = rdata_q;
  always @(posedge clk) begin
    if (buf_we) mem[buf_waddr] <= buf_wdata;
    rdata_q <= mem[buf_raddr];
  end

  int   ucnt = 0;
  logic u_fire;
  logic hold_busy = 1'b0;
  assign tx_busy = hold_busy | (ucnt != 0);
  always begin
    @(negedge clk);
    u_fire = tx_wr;
    @(posedge clk);
    #1;
    if (rst)              ucnt = 0;
    else if (u_fire)      ucnt = 10;
    else if (ucnt != 0)   ucnt--;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (buf_we) begin
        wr_seen++;
        if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", 32'(buf_waddr), 32'(e.a));
          chk("wr_data", 32'(buf_wdata), 32'(e.d));
        end
      end
      if (tx_wr) begin
        tx_seen++;
        if (exp_tx.size() == 0) chk("tx_extra", 1, 0);
        else chk("tx_data", 32'(tx_data), 32'(exp_tx.pop_front()));
      end
    end
  end

  task automatic do_arm();
    @(posedge clk); #1;
    arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
  endtask

  task automatic send_frame(int n, bit drop_first, bit end_on_last,
                            logic [7:0] base);
    wr_t e;
    @(posedge clk); #1;
    frame_start = 1'b1;
    pix_valid   = drop_first;
    pix_data    = 8'hEE;
    @(posedge clk); #1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = base + 8'(i);
      if (i < FP) begin
        e.a = AW'(i);
        e.d = pix_data;
        exp_wr.push_back(e);
        exp_tx.push_back(pix_data);
      end
      if (end_on_last && i == n - 1) frame_end = 1'b1;
      @(posedge clk); #1;
      pix_valid = 1'b0;
      frame_end = 1'b0;
    end
    if (!end_on_last) begin
      frame_end = 1'b1;
      @(posedge clk); #1;
      frame_end = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("done_to", 32'(done), 1);
  endtask

  task automatic frame_check(string tag, int n, logic ovf);
    chk({tag, "_cnt"}, 32'(pix_count), 32'(n));
    chk({tag, "_ovf"}, 32'(overflow), 32'(ovf));
    chk({tag, "_wrs"}, 32'(wr_seen), 32'(n));
    chk({tag, "_txs"}, 32'(tx_seen), 32'(n));
    chk({tag, "_qe"}, 32'(exp_wr.size() + exp_tx.size()), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic new_frame();
    wr_seen = 0;
    tx_seen = 0;
  endtask

  initial begin
    int n;
    int base_tx;
    int base_wr;
    rst = 1'b1; arm = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_cnt", 32'(pix_count), 0);
    chk("rst_we", 32'(buf_we), 0);
    chk("rst_txwr", 32'(tx_wr), 0);
    chk("rst_txd", 32'(tx_data), 0);
    chk("rst_wa", 32'(buf_waddr), 0);
    chk("rst_ra", 32'(buf_raddr), 0);

    new_frame();
    do_arm();
    send_frame(8, 0, 0, 8'h10);
    wait_done();
    frame_check("f8", 8, 1'b0);

    new_frame();
    do_arm();
    send_frame(20, 0, 0, 8'h30);
    wait_done();
    frame_check("f20", 16, 1'b1);

    new_frame();
    do_arm();
    send_frame(3, 1, 1, 8'hA0);
    wait_done();
    frame_check("fdrop", 3, 1'b0);

    new_frame();
    do_arm();
    @(posedge clk); #1;
    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("fe_early_busy", 32'(busy), 1);
    chk("fe_early_done", 32'(done), 0);
    send_frame(0, 0, 0, 8'h00);
    @(negedge clk);
    chk("f0_done", 32'(done), 1);
    repeat (20) @(negedge clk);
    frame_check("f0", 0, 1'b0);

    new_frame();
    do_arm();
    send_frame(4, 0, 0, 8'h60);
    n = 0;
    while (tx_seen < 1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("hold_first_to", 32'(tx_seen), 1);
    @(posedge clk); #1;
    hold_busy = 1'b1;
    base_tx = tx_seen;
    repeat (50) @(posedge clk);
    chk("hold_no_tx", 32'(tx_seen), 32'(base_tx));
    #1;
    hold_busy = 1'b0;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (tx_wr) break;
    end
    chk("holdoff_gap", 32'(n), 32'(HO + 1));
    wait_done();
    frame_check("fhold", 4, 1'b0);

    new_frame();
    do_arm();
    send_frame(8, 0, 0, 8'h70);
    n = 0;
    while (tx_seen < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mid_to", 32'(tx_seen), 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_done", 32'(done), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_wr.delete();
    exp_tx.delete();
    base_tx = tx_seen;
    base_wr = wr_seen;
    repeat (60) @(negedge clk);
    chk("rst_mid_notx", 32'(tx_seen), 32'(base_tx));
    chk("rst_mid_nowr", 32'(wr_seen), 32'(base_wr));

    new_frame();
    do_arm();
    send_frame(2, 0, 0, 8'h50);
    wait_done();
    frame_check("frearm", 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
